// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        req;    // fetch request valid
  logic [31:0] addr;   // word-aligned fetch address
  logic [31:0] rdata;  // instruction word, meaningful when ready=1
  logic        ready;  // fetch completes this cycle

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, drives the imem handshake, honours hazard-unit stalls and
// applies ID-resolved redirects with an optional architectural delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DELAY_SLOT = 1,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_pc_write,
  input  logic          i_if_id_write,
  input  logic          i_redirect,
  input  logic [31:0]   i_redirect_pc,
  fetch_stage_if.master imem,
  output logic [31:0]   o_if_id_instr,
  output logic [31:0]   o_if_id_pc4,
  output logic          o_if_id_valid,
  output logic [5:0]    o_if_id_op,
  output logic [5:0]    o_if_id_func,
  output logic [4:0]    o_if_id_rs,
  output logic [4:0]    o_if_id_rt
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PEND  = 2'd2;
  localparam logic       P_DS     = (DELAY_SLOT != 0);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_req;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pend_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc4_nxt;
  logic        w_valid_nxt;
  logic        w_load_word;
  logic        w_load_bubble;
  logic        w_fire;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign w_target   = i_redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_fire     = r_req & imem.ready;

  assign imem.req  = r_req;
  assign imem.addr = r_pc;

  assign o_if_id_instr = r_instr;
  assign o_if_id_pc4   = r_pc4;
  assign o_if_id_valid = r_valid;
  assign o_if_id_op    = r_instr[31:26];
  assign o_if_id_func  = r_instr[5:0];
  assign o_if_id_rs    = r_instr[25:21];
  assign o_if_id_rt    = r_instr[20:16];

  // Sequencing: PC, pending delay-slot target and what IF/ID should capture.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_nxt    = r_pend_pc;
    w_load_word   = 1'b0;
    w_load_bubble = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!i_pc_write) begin
          // Stall: an unstable ID branch decision must not move the PC.
          w_load_word = i_if_id_write & w_fire;
        end else if (i_redirect && !P_DS) begin
          w_pc_nxt      = w_target;
          w_load_bubble = 1'b1;
        end else if (i_redirect && imem.ready) begin
          w_pc_nxt    = w_target;
          w_load_word = 1'b1;
        end else if (i_redirect) begin
          // Delay-slot word still outstanding: park the target until it lands.
          w_pend_nxt    = w_target;
          w_state_nxt   = ST_PEND;
          w_load_bubble = i_if_id_write;
        end else if (imem.ready) begin
          w_pc_nxt    = w_pc_plus4;
          w_load_word = i_if_id_write;
        end else begin
          w_load_bubble = i_if_id_write;
        end
      end
      ST_PEND: begin
        if (!i_pc_write || !i_if_id_write) begin
          w_state_nxt = ST_PEND;
        end else if (imem.ready) begin
          w_pc_nxt    = r_pend_pc;
          w_load_word = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_load_bubble = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // IF/ID next contents: fetched word, bubble, or hold.
  always_comb begin
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    if (w_load_word) begin
      w_instr_nxt = imem.rdata;
      w_pc4_nxt   = w_pc_plus4;
      w_valid_nxt = 1'b1;
    end else if (w_load_bubble) begin
      w_instr_nxt = NOP_WORD;
      w_pc4_nxt   = 32'h0000_0000;
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_valid;
    end
  end

  // State, PC and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_pend_pc <= 32'h0000_0000;
      r_req     <= 1'b0;
      r_instr   <= NOP_WORD;
      r_pc4     <= 32'h0000_0000;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
      r_req     <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_PEND);
      r_instr   <= w_instr_nxt;
      r_pc4     <= w_pc4_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  fetch_stage_chk u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_in_fetch    (r_state == ST_FETCH),
    .i_pc_write    (i_pc_write),
    .i_if_id_write (i_if_id_write),
    .i_fire        (w_fire)
  );

endmodule

// Input-legality checks for the fetch stage.
module fetch_stage_chk (
  input logic clk,
  input logic rst_n,
  input logic i_in_fetch,
  input logic i_pc_write,
  input logic i_if_id_write,
  input logic i_fire
);
  // Advancing the PC while IF/ID is frozen would silently drop a fetched word.
  a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_in_fetch && i_pc_write && !i_if_id_write && i_fire))
    else $error("fetch_stage: pc_write=1 with if_id_write=0 on a completing fetch");
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: two instances (delay slot off/on)
// driven by the same stimulus, compared against a behavioural model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, if_id_write, redirect, ready;
  logic [31:0] redirect_pc;

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();

  logic [31:0] o_instr [2];
  logic [31:0] o_pc4   [2];
  logic        o_valid [2];
  logic [5:0]  o_op    [2];
  logic [5:0]  o_func  [2];
  logic [4:0]  o_rs    [2];
  logic [4:0]  o_rt    [2];
  logic [31:0] o_addr  [2];
  logic        o_req   [2];

  int n_err = 0;
  int n_chk = 0;

  // Behavioural model per instance (index 0: no delay slot, 1: delay slot).
  bit          m_boot  [2];
  bit          m_pend  [2];
  bit          m_valid [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_tgt   [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_pc4   [2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h8C21_7F35;
  endfunction

  assign bus0.rdata = mem_word(bus0.addr);
  assign bus1.rdata = mem_word(bus1.addr);
  assign bus0.ready = ready;
  assign bus1.ready = ready;
  assign o_addr[0]  = bus0.addr;
  assign o_addr[1]  = bus1.addr;
  assign o_req[0]   = bus0.req;
  assign o_req[1]   = bus1.req;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(0), .NOP_WORD(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_pc_write(pc_write), .i_if_id_write(if_id_write),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .imem(bus0),
    .o_if_id_instr(o_instr[0]), .o_if_id_pc4(o_pc4[0]), .o_if_id_valid(o_valid[0]),
    .o_if_id_op(o_op[0]), .o_if_id_func(o_func[0]), .o_if_id_rs(o_rs[0]), .o_if_id_rt(o_rt[0]));

  fetch_stage #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(1), .NOP_WORD(32'h0000_0000)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_pc_write(pc_write), .i_if_id_write(if_id_write),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .imem(bus1),
    .o_if_id_instr(o_instr[1]), .o_if_id_pc4(o_pc4[1]), .o_if_id_valid(o_valid[1]),
    .o_if_id_op(o_op[1]), .o_if_id_func(o_func[1]), .o_if_id_rs(o_rs[1]), .o_if_id_rt(o_rt[1]));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_boot[d] = 1'b1; m_pend[d] = 1'b0; m_valid[d] = 1'b0;
      m_pc[d] = 32'h0; m_tgt[d] = 32'h0; m_instr[d] = 32'h0; m_pc4[d] = 32'h0;
    end
  endtask

  task automatic m_load(input int d, input logic [31:0] w, input logic [31:0] p4);
    m_instr[d] = w; m_pc4[d] = p4; m_valid[d] = 1'b1;
  endtask

  task automatic m_bubble(input int d);
    m_instr[d] = 32'h0; m_pc4[d] = 32'h0; m_valid[d] = 1'b0;
  endtask

  // What one rising edge does, given the inputs currently applied.
  task automatic model_step(input int d);
    logic [31:0] w, t, p4;
    w  = mem_word(m_pc[d]);
    t  = redirect_pc & 32'hFFFF_FFFC;
    p4 = m_pc[d] + 32'd4;
    if (m_boot[d]) begin
      m_boot[d] = 1'b0;
    end else if (m_pend[d]) begin
      if (pc_write && if_id_write && ready) begin
        m_load(d, w, p4); m_pc[d] = m_tgt[d]; m_pend[d] = 1'b0;
      end else if (pc_write && if_id_write) begin
        m_bubble(d);
      end
    end else if (!pc_write) begin
      if (if_id_write && ready) m_load(d, w, p4);
    end else if (redirect && d == 0) begin
      m_pc[d] = t; m_bubble(d);
    end else if (redirect && ready) begin
      m_load(d, w, p4); m_pc[d] = t;
    end else if (redirect) begin
      m_tgt[d] = t; m_pend[d] = 1'b1;
      if (if_id_write) m_bubble(d);
    end else if (ready) begin
      if (if_id_write) m_load(d, w, p4);
      m_pc[d] = p4;
    end else if (if_id_write) begin
      m_bubble(d);
    end
  endtask

  task automatic set_idle();
    pc_write = 1'b1; if_id_write = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to(input logic [31:0] target);
    int k;
    set_idle();
    k = 0;
    while (k < 64 && !(m_pc[1] == target && !m_boot[1])) begin
      tick();
      k++;
    end
    n_chk++;
    if (m_pc[1] != target) begin
      n_err++; $display("FAIL run_to got=%h exp=%h", m_pc[1], target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    model_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_req[d] !== 1'b0 || o_addr[d] !== 32'h0 || o_valid[d] !== 1'b0 || o_instr[d] !== 32'h0 || o_pc4[d] !== 32'h0) begin
        n_err++; $display("FAIL reset_state dut%0d got req=%b addr=%h valid=%b instr=%h pc4=%h exp 0", d, o_req[d], o_addr[d], o_valid[d], o_instr[d], o_pc4[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_req[d] !== 1'b0) begin n_err++; $display("FAIL boot_req dut%0d got=%b exp=0", d, o_req[d]); end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_req[d] !== 1'b1 || o_addr[d] !== 32'h0 || o_valid[d] !== 1'b0) begin
        n_err++; $display("FAIL first_fetch dut%0d got req=%b addr=%h valid=%b exp 1/0/0", d, o_req[d], o_addr[d], o_valid[d]);
      end
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_chk++; if (o_addr[d] !== 32'(c * 4) || o_pc4[d] !== 32'(c * 4) || o_valid[d] !== 1'b1 || o_instr[d] !== mem_word(32'((c - 1) * 4))) begin
          n_err++; $display("FAIL seq dut%0d c=%0d got addr=%h pc4=%h valid=%b instr=%h exp addr=pc4=%h", d, c, o_addr[d], o_pc4[d], o_valid[d], o_instr[d], 32'(c * 4));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    do_reset();
    run_to(32'h10);
    w = mem_word(32'hC);
    pc_write = 1'b0; if_id_write = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_chk++; if (o_addr[d] !== 32'h10 || o_instr[d] !== w || o_rs[d] !== w[25:21] || o_rt[d] !== w[20:16] || o_pc4[d] !== 32'h10) begin
          n_err++; $display("FAIL stall_hold dut%0d got addr=%h instr=%h rs=%h rt=%h exp addr=10 instr=%h", d, o_addr[d], o_instr[d], o_rs[d], o_rt[d], w);
        end
      end
    end
    set_idle();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_addr[d] !== 32'h14 || o_instr[d] !== mem_word(32'h10) || o_pc4[d] !== 32'h14) begin
        n_err++; $display("FAIL stall_resume dut%0d got addr=%h instr=%h pc4=%h exp addr=14 pc4=14", d, o_addr[d], o_instr[d], o_pc4[d]);
      end
    end
  endtask

  task automatic test_redirect_ready();
    do_reset();
    run_to(32'h20);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    n_chk++; if (o_instr[1] !== mem_word(32'h20) || o_pc4[1] !== 32'h24 || o_valid[1] !== 1'b1 || o_addr[1] !== 32'h100) begin
      n_err++; $display("FAIL redir_ds1 got instr=%h pc4=%h valid=%b addr=%h exp instr=%h pc4=24 valid=1 addr=100", o_instr[1], o_pc4[1], o_valid[1], o_addr[1], mem_word(32'h20));
    end
    n_chk++; if (o_instr[0] !== 32'h0 || o_valid[0] !== 1'b0 || o_addr[0] !== 32'h100 || o_op[0] !== 6'h0 || o_func[0] !== 6'h0) begin
      n_err++; $display("FAIL redir_ds0 got instr=%h valid=%b addr=%h exp instr=0 valid=0 addr=100", o_instr[0], o_valid[0], o_addr[0]);
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_instr[d] !== mem_word(32'h100) || o_pc4[d] !== 32'h104 || o_addr[d] !== 32'h104) begin
        n_err++; $display("FAIL redir_target dut%0d got instr=%h pc4=%h addr=%h exp pc4=104 addr=104", d, o_instr[d], o_pc4[d], o_addr[d]);
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    run_to(32'h20);
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    for (int c = 0; c < 3; c++) begin
      tick();
      redirect_pc = 32'h300;  // further redirects must not disturb the parked target
      n_chk++; if (o_addr[1] !== 32'h20 || o_req[1] !== 1'b1 || o_valid[1] !== 1'b0) begin
        n_err++; $display("FAIL pend_hold c=%0d got addr=%h req=%b valid=%b exp addr=20 req=1 valid=0", c, o_addr[1], o_req[1], o_valid[1]);
      end
      n_chk++; if (o_addr[0] !== m_pc[0] || o_valid[0] !== m_valid[0]) begin
        n_err++; $display("FAIL pend_ds0 c=%0d got addr=%h valid=%b exp addr=%h valid=%b", c, o_addr[0], o_valid[0], m_pc[0], m_valid[0]);
      end
    end
    redirect = 1'b0; ready = 1'b1;
    tick();
    n_chk++; if (o_instr[1] !== mem_word(32'h20) || o_pc4[1] !== 32'h24 || o_valid[1] !== 1'b1 || o_addr[1] !== 32'h100) begin
      n_err++; $display("FAIL pend_done got instr=%h pc4=%h valid=%b addr=%h exp pc4=24 valid=1 addr=100", o_instr[1], o_pc4[1], o_valid[1], o_addr[1]);
    end
    tick();
    n_chk++; if (o_instr[1] !== mem_word(32'h100) || o_addr[1] !== 32'h104) begin
      n_err++; $display("FAIL pend_target got instr=%h addr=%h exp instr=%h addr=104", o_instr[1], o_addr[1], mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_stalled();
    do_reset();
    run_to(32'h10);
    pc_write = 1'b0; if_id_write = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_addr[d] !== 32'h10) begin n_err++; $display("FAIL stalled_redir dut%0d got addr=%h exp 10", d, o_addr[d]); end
    end
    set_idle();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_addr[d] !== 32'h14) begin n_err++; $display("FAIL stalled_resume dut%0d got addr=%h exp 14", d, o_addr[d]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_to(32'h10);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_addr[d] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_target dut%0d got addr=%h exp fffffffc", d, o_addr[d]); end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_addr[d] !== 32'h0 || o_pc4[d] !== 32'h0 || o_valid[d] !== 1'b1 || o_instr[d] !== mem_word(32'hFFFF_FFFC)) begin
        n_err++; $display("FAIL wrap_pc4 dut%0d got addr=%h pc4=%h valid=%b exp addr=0 pc4=0 valid=1", d, o_addr[d], o_pc4[d], o_valid[d]);
      end
    end
  endtask

  task automatic test_reset_mid_pend();
    do_reset();
    run_to(32'h20);
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_addr[d] !== 32'h0 || o_valid[d] !== 1'b0 || o_req[d] !== 1'b0) begin
        n_err++; $display("FAIL async_reset dut%0d got addr=%h valid=%b req=%b exp 0", d, o_addr[d], o_valid[d], o_req[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (o_addr[d] !== 32'h4 || o_pc4[d] !== 32'h4) begin
        n_err++; $display("FAIL pend_cleared dut%0d got addr=%h pc4=%h exp 4", d, o_addr[d], o_pc4[d]);
      end
    end
  endtask

  task automatic test_random();
    bit stall;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      pc_write    = !stall;
      if_id_write = !stall;
      ready       = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 9) < 2);
      redirect_pc = $urandom;
      tick();
      for (int d = 0; d < 2; d++) begin
        n_chk++; if (o_addr[d] !== m_pc[d] || o_req[d] !== 1'b1 || o_valid[d] !== m_valid[d] || o_instr[d] !== m_instr[d]) begin
          n_err++; $display("FAIL rand c=%0d dut%0d got addr=%h req=%b valid=%b instr=%h exp addr=%h req=1 valid=%b instr=%h",
                            c, d, o_addr[d], o_req[d], o_valid[d], o_instr[d], m_pc[d], m_valid[d], m_instr[d]);
        end
        n_chk++; if (o_op[d] !== m_instr[d][31:26] || o_func[d] !== m_instr[d][5:0] || o_rs[d] !== m_instr[d][25:21] || o_rt[d] !== m_instr[d][20:16]) begin
          n_err++; $display("FAIL rand_decode c=%0d dut%0d got op=%h func=%h rs=%h rt=%h", c, d, o_op[d], o_func[d], o_rs[d], o_rt[d]);
        end
        if (m_valid[d]) begin
          n_chk++; if (o_pc4[d] !== m_pc4[d]) begin
            n_err++; $display("FAIL rand_pc4 c=%0d dut%0d got=%h exp=%h", c, d, o_pc4[d], m_pc4[d]);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_stall();
    test_redirect_ready();
    test_redirect_wait();
    test_redirect_stalled();
    test_wrap();
    test_reset_mid_pend();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
